// File: rtl/secure_mem_gate.sv
`default_nettype none
// ============================================================================
// Module      : secure_mem_gate
// Description : Key-gated, pipelined access filter in front of a synchronous
//               memory. Addresses at or above PROT_BASE are scrambled on write
//               and descrambled on read, but only while the unlock FSM is
//               UNLOCKED. Repeated bad keys lead to a timed lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_mem_gate #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 10,
    parameter int                KEY_W       = 16,
    parameter logic [KEY_W-1:0]  KEY_VALUE   = 16'h0032,
    parameter int                PROT_BASE   = 129,
    parameter int                MAX_FAIL    = 3,
    parameter int                LOCK_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              lock_req,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rd_data_vld,
    output logic [DATA_W-1:0] rd_data,
    output logic              unlocked,
    output logic              locked_out,
    output logic              viol
);

    // Multiplicative inverse of 3 modulo 2^DATA_W, built in a wider word so
    // the (2^k + 1) / 3 division does not overflow.
    function automatic logic [DATA_W-1:0] f_inv3();
        logic [DATA_W+1:0] t;
        t = '0;
        if ((DATA_W % 2) == 0) t[DATA_W+1] = 1'b1;
        else                   t[DATA_W]   = 1'b1;
        t[0] = 1'b1;
        t = t / (DATA_W+2)'(3);
        return t[DATA_W-1:0];
    endfunction

    localparam int                c_fail_w      = $clog2(MAX_FAIL + 1);
    localparam int                c_timer_w     = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_fail_w-1:0]  c_fail_last   = c_fail_w'(MAX_FAIL - 1);
    localparam logic [c_timer_w-1:0] c_lock_cycles = c_timer_w'(LOCK_CYCLES);
    localparam logic [c_timer_w-1:0] c_timer_one   = c_timer_w'(1);
    localparam logic [ADDR_W-1:0] c_prot_base   = ADDR_W'(PROT_BASE);
    localparam logic [DATA_W-1:0] c_two         = DATA_W'(2);
    localparam logic [DATA_W-1:0] c_three       = DATA_W'(3);
    localparam logic [DATA_W-1:0] c_nine        = DATA_W'(9);
    localparam logic [DATA_W-1:0] c_inv3        = f_inv3();

    // Forward transform: subtract 3, xor 2, add 9, multiply by 3.
    function automatic logic [DATA_W-1:0] f_scramble(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] t;
        t = (d - c_three) ^ c_two;
        t = t + c_nine;
        return t * c_three;
    endfunction

    // Inverse transform, undoing each forward step in reverse order.
    function automatic logic [DATA_W-1:0] f_descramble(input logic [DATA_W-1:0] e);
        logic [DATA_W-1:0] t;
        t = e * c_inv3;
        t = (t - c_nine) ^ c_two;
        return t + c_three;
    endfunction

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_fail_w-1:0]   r_fail_cnt, w_fail_nxt;
    logic [c_timer_w-1:0]  r_timer, w_timer_nxt;

    logic w_unl, w_wr_prot, w_rd_prot, w_wr_ok, w_rd_ok;
    logic r_s1_vld, r_s1_desc, r_s1_deny;
    logic r_s2_vld, r_s2_desc, r_s2_deny;

    // Access decisions use the registered (pre-edge) FSM state.
    assign w_unl      = (r_state == ST_UNLOCKED);
    assign w_wr_prot  = (wr_addr >= c_prot_base);
    assign w_rd_prot  = (rd_addr >= c_prot_base);
    assign w_wr_ok    = !w_wr_prot || w_unl;
    assign w_rd_ok    = !w_rd_prot || w_unl;
    assign unlocked   = (r_state == ST_UNLOCKED);
    assign locked_out = (r_state == ST_LOCKOUT);

    // FSM state, failure counter and lockout timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_LOCKED;
            r_fail_cnt <= '0;
            r_timer    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    // Next-state logic: key attempts, relock requests and lockout countdown.
    always_comb begin
        w_state_nxt = r_state;
        w_fail_nxt  = r_fail_cnt;
        w_timer_nxt = r_timer;
        case (r_state)
            ST_LOCKED: begin
                if (key_valid) begin
                    if (key_in == KEY_VALUE) begin
                        w_state_nxt = ST_UNLOCKED;
                        w_fail_nxt  = '0;
                    end else if (r_fail_cnt == c_fail_last) begin
                        w_state_nxt = ST_LOCKOUT;
                        w_timer_nxt = c_lock_cycles;
                        w_fail_nxt  = '0;
                    end else begin
                        w_fail_nxt  = r_fail_cnt + 1'b1;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (lock_req) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKOUT: begin
                if (r_timer == c_timer_one) begin
                    w_state_nxt = ST_LOCKED;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_state_nxt = ST_LOCKED;
        endcase
    end

    // Write path: one-cycle registered pass-through or scramble; denied writes never reach memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            mem_wr_en <= wr_valid && w_wr_ok;
            if (wr_valid && w_wr_ok) begin
                mem_wr_addr <= wr_addr;
                mem_wr_data <= w_wr_prot ? f_scramble(wr_data) : wr_data;
            end
        end
    end

    // Read request stage plus the access flags carried alongside each request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_desc   <= 1'b0;
            r_s1_deny   <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_desc   <= 1'b0;
            r_s2_deny   <= 1'b0;
        end else begin
            mem_rd_en <= rd_valid && w_rd_ok;
            if (rd_valid && w_rd_ok) mem_rd_addr <= rd_addr;
            r_s1_vld  <= rd_valid;
            r_s1_desc <= rd_valid && w_rd_prot && w_unl;
            r_s1_deny <= rd_valid && !w_rd_ok;
            r_s2_vld  <= r_s1_vld;
            r_s2_desc <= r_s1_desc;
            r_s2_deny <= r_s1_deny;
        end
    end

    // Read result stage: memory data arrives alongside stage-2 flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_vld <= 1'b0;
            rd_data     <= '0;
        end else begin
            rd_data_vld <= r_s2_vld;
            if (!r_s2_vld || r_s2_deny) rd_data <= '0;
            else if (r_s2_desc)         rd_data <= f_descramble(mem_rd_data);
            else                        rd_data <= mem_rd_data;
        end
    end

    // Violation pulse: any protected request issued while not unlocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) viol <= 1'b0;
        else        viol <= (wr_valid && !w_wr_ok) || (rd_valid && !w_rd_ok);
    end

endmodule
`default_nettype wire

// File: tb/tb_secure_mem_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_secure_mem_gate
// Description : Directed and random testbench for secure_mem_gate with a
//               synchronous memory model and an in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_secure_mem_gate;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int KEY_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_valid, lock_req, wr_valid, rd_valid;
    logic [KEY_W-1:0]  key_in;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;
    logic              mem_wr_en, mem_rd_en, rd_data_vld, unlocked, locked_out, viol;
    logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;
    logic [DATA_W-1:0] mem_wr_data, mem_rd_data, rd_data;

    logic [DATA_W-1:0] mem [0:1023];
    logic [DATA_W-1:0] mem_q = '0;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [DATA_W-1:0] wq_data[$];
    logic [DATA_W-1:0] rq_data[$];

    int n_checks = 0;
    int n_fail   = 0;

    secure_mem_gate dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
        .lock_req(lock_req), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data), .unlocked(unlocked),
        .locked_out(locked_out), .viol(viol)
    );

    always #5 clk = ~clk;

    // Synchronous memory, read-old-data on same-address collision.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_q <= mem[mem_rd_addr];
    end
    assign mem_rd_data = mem_q;

    function automatic logic [31:0] scr(input logic [31:0] d);
        logic [31:0] t;
        t = d - 32'd3;
        t = t ^ 32'd2;
        t = t + 32'd9;
        return t * 32'd3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare any DUT output against the scoreboard.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (mem_wr_en) begin
            if (wq_addr.size() == 0) check("wr_unexpected", 32'(mem_wr_en), 32'd0);
            else begin
                check("wr_addr", 32'(mem_wr_addr), 32'(wq_addr.pop_front()));
                check("wr_data", mem_wr_data, wq_data.pop_front());
            end
        end
        if (rd_data_vld) begin
            if (rq_data.size() == 0) check("rd_unexpected", 32'(rd_data_vld), 32'd0);
            else check("rd_data", rd_data, rq_data.pop_front());
        end
    endtask

    task automatic idle();
        key_valid = 1'b0; key_in = '0; lock_req = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [31:0] exp_mem);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        wq_addr.push_back(a); wq_data.push_back(exp_mem);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [31:0] exp_d);
        rd_valid = 1'b1; rd_addr = a;
        rq_data.push_back(exp_d);
    endtask

    task automatic key(input logic [15:0] k);
        key_valid = 1'b1; key_in = k; tick(); key_valid = 1'b0;
    endtask

    initial begin
        logic [9:0]  ra [8];
        logic [31:0] rdat [8];
        int cnt;

        idle();
        repeat (3) tick();
        // 1: reset state and denied protected write
        check("rst_flags", 32'({mem_wr_en, mem_rd_en, rd_data_vld, unlocked, locked_out, viol}), 32'd0);
        check("rst_wr_data", mem_wr_data, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        tick();
        wr_valid = 1'b1; wr_addr = 10'd200; wr_data = 32'h10;
        tick();
        idle();
        check("deny_wr_en", 32'(mem_wr_en), 32'd0);
        check("deny_wr_viol", 32'(viol), 32'd1);
        tick();
        check("viol_pulse", 32'(viol), 32'd0);

        // 2: unlock, scrambled write and descrambled read
        key(16'h0032);
        check("unlock", 32'(unlocked), 32'd1);
        do_write(10'd200, 32'h10, 32'h48);
        tick(); idle();
        tick();
        do_read(10'd200, 32'h10);
        tick(); idle();
        check("rd_en_prot", 32'(mem_rd_en), 32'd1);
        repeat (3) tick();

        // 3: locked pass-through below the boundary, denied read above it
        lock_req = 1'b1; tick(); idle();
        check("relock", 32'(unlocked), 32'd0);
        do_write(10'd128, 32'hDEADBEEF, 32'hDEADBEEF);
        tick();
        do_write(10'd5, 32'h12345678, 32'h12345678);
        tick(); idle();
        tick();
        do_read(10'd5, 32'h12345678);
        tick();
        do_read(10'd128, 32'hDEADBEEF);
        tick();
        do_read(10'd129, 32'h0);
        tick(); idle();
        check("deny_rd_viol", 32'(viol), 32'd1);
        check("deny_rd_en", 32'(mem_rd_en), 32'd0);
        repeat (4) tick();

        // 4: lockout after three bad keys, correct key ignored meanwhile
        key_valid = 1'b1; key_in = 16'h0000;
        tick(); tick();
        check("no_lockout_yet", 32'(locked_out), 32'd0);
        tick();
        check("lockout", 32'(locked_out), 32'd1);
        key_in = 16'h0032;
        cnt = 1;
        for (int i = 0; i < 400 && locked_out; i++) begin
            tick();
            if (locked_out) cnt++;
        end
        key_valid = 1'b0;
        check("lockout_len", 32'(cnt), 32'd256);
        check("lockout_end", 32'(locked_out), 32'd0);
        check("lockout_key_ign", 32'(unlocked), 32'd0);
        tick();
        check("locked_after", 32'(unlocked), 32'd0);
        key(16'h0032);
        check("unlock_after_lo", 32'(unlocked), 32'd1);
        // failure count clears on a successful key
        lock_req = 1'b1; tick(); idle();
        key(16'h0001); key(16'h0002); key(16'h0032);
        check("unlock_2bad", 32'(unlocked), 32'd1);
        lock_req = 1'b1; tick(); idle();
        key(16'h0003); key(16'h0004);
        check("fail_cnt_cleared", 32'(locked_out), 32'd0);
        key(16'h0032);

        // 5: lock_req beats key_valid; same-cycle read still descrambles
        lock_req = 1'b1; key_valid = 1'b1; key_in = 16'h0032;
        do_read(10'd200, 32'h10);
        tick(); idle();
        check("lock_wins", 32'(unlocked), 32'd0);
        check("lock_wins_viol", 32'(viol), 32'd0);
        repeat (3) tick();

        // 6a: reset while a read is in flight discards it
        rd_valid = 1'b1; rd_addr = 10'd5;
        tick(); idle();
        #2 rst_n = 1'b0;
        #1 check("rst_mid_vld", 32'(rd_data_vld), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_vld", 32'(rd_data_vld), 32'd0);
        end
        check("post_rst_lock", 32'(unlocked), 32'd0);

        // 6b: random protected round-trip, back-to-back bursts
        key(16'h0032);
        for (int b = 0; b < 125; b++) begin
            for (int i = 0; i < 8; i++) begin
                ra[i]   = 10'(300 + i * 8 + (b % 8));
                rdat[i] = $urandom;
                do_write(ra[i], rdat[i], scr(rdat[i]));
                tick();
            end
            idle();
            for (int i = 0; i < 8; i++) begin
                do_read(ra[i], rdat[i]);
                tick();
            end
            idle();
            repeat (3) tick();
        end

        check("wq_drained", 32'(wq_addr.size()), 32'd0);
        check("rq_drained", 32'(rq_data.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
